// File: rtl/fp_mul_sequencer_if.sv
// Operand/result handshake bundle for fp_mul_sequencer.
// Both channels use valid/ready. A transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that edge. Ready may be high without valid.
// The state field is a read-only view of the controller FSM.
interface fp_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             invalid;
    logic             overflow;
    logic             underflow;
    logic [1:0]       state;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, invalid, overflow, underflow, state
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, invalid, overflow, underflow, state
    );
endinterface

// File: rtl/fp_mul_sequencer.sv
// Multi-cycle single-precision multiplier controller.
// Special operands are resolved at accept time. Other operands run a
// shift-add mantissa multiply, one multiplier bit per cycle. The product is
// then normalised and rounded to nearest-even. Denormal inputs count as zero.
// Out-of-range exponents saturate to infinity or flush to zero.
module fp_mul_sequencer #(
    parameter int EXPONENT_BITS = 8,
    parameter int FRACTION_BITS = 23
) (
    input logic              clock,
    input logic              reset,
    fp_mul_sequencer_if.slave bus
);
    localparam int W    = 1 + EXPONENT_BITS + FRACTION_BITS;
    localparam int M    = FRACTION_BITS + 1;          // mantissa width incl. hidden bit
    localparam int P    = 2 * M;                      // full product width
    localparam int XW   = EXPONENT_BITS + 2;          // signed working exponent width
    localparam int CW   = $clog2(M);
    localparam int BIAS = (1 << (EXPONENT_BITS - 1)) - 1;

    localparam logic [EXPONENT_BITS-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(FRACTION_BITS-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXPONENT_BITS) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic [CW-1:0] LAST_ITER = CW'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state;
    logic                     sign_r;
    logic [EXPONENT_BITS-1:0] exp_a;
    logic [EXPONENT_BITS-1:0] exp_b;
    logic [M-1:0]             mcand;
    logic [M-1:0]             mplier;
    logic [P-1:0]             acc;
    logic [CW-1:0]            iter;
    logic [W-1:0]             result_r;
    logic                     invalid_r;
    logic                     overflow_r;
    logic                     underflow_r;
    logic                     out_valid_r;
    logic                     in_ready_r;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.invalid   = invalid_r;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
    assign bus.state     = state;

    // Operand classification, taken straight from the input bus at accept time.
    logic                     a_sign, b_sign;
    logic [EXPONENT_BITS-1:0] a_exp, b_exp;
    logic [FRACTION_BITS-1:0] a_frac, b_frac;
    logic                     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                     is_special, special_invalid;
    logic [W-1:0]             special_result;

    assign {a_sign, a_exp, a_frac} = bus.a;
    assign {b_sign, b_exp, b_frac} = bus.b;
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // Special-case result in priority order: NaN, inf*0, inf, zero.
    always_comb begin
        special_invalid = 1'b0;
        special_result  = '0;
        if (a_nan || b_nan) begin
            special_result = QNAN;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            special_result  = QNAN;
            special_invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            special_result = {a_sign ^ b_sign, EXP_ONES, {FRACTION_BITS{1'b0}}};
        end else begin
            special_result = {a_sign ^ b_sign, {(W-1){1'b0}}};
        end
    end

    // One shift-add step: add the multiplicand into the upper half, shift right.
    logic [M:0] step_sum;
    assign step_sum = {1'b0, acc[P-1:M]} + (mplier[0] ? {1'b0, mcand} : {(M+1){1'b0}});

    // Normalise, round to nearest-even and range-check the finished product.
    logic signed [XW-1:0] exp_base, exp_norm, exp_fin;
    logic [M-1:0]         mant, mant_fin;
    logic [M:0]           mant_rnd;
    logic                 guard, sticky, round_up;
    logic                 norm_ovf, norm_unf;
    logic [W-1:0]         norm_result;

    always_comb begin
        exp_base = XW'({2'b00, exp_a}) + XW'({2'b00, exp_b}) - XW'(BIAS);
        if (acc[P-1]) begin
            mant     = acc[P-1:M];
            guard    = acc[M-1];
            sticky   = |acc[M-2:0];
            exp_norm = exp_base + XW'(1);
        end else begin
            mant     = acc[P-2:M-1];
            guard    = acc[M-2];
            sticky   = |acc[M-3:0];
            exp_norm = exp_base;
        end
        round_up = guard && (sticky || mant[0]);
        mant_rnd = {1'b0, mant} + {{M{1'b0}}, round_up};
        if (mant_rnd[M]) begin
            mant_fin = {1'b1, {(M-1){1'b0}}};
            exp_fin  = exp_norm + XW'(1);
        end else begin
            mant_fin = mant_rnd[M-1:0];
            exp_fin  = exp_norm;
        end
        norm_ovf = (exp_fin >= EXP_MAX);
        norm_unf = !norm_ovf && (exp_fin <= EXP_ZERO);
        if (norm_ovf) begin
            norm_result = {sign_r, EXP_ONES, {FRACTION_BITS{1'b0}}};
        end else if (norm_unf) begin
            norm_result = {sign_r, {(W-1){1'b0}}};
        end else begin
            norm_result = {sign_r, exp_fin[EXPONENT_BITS-1:0], mant_fin[FRACTION_BITS-1:0]};
        end
    end

    // Controller FSM with registered handshake outputs, result and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sign_r      <= 1'b0;
            exp_a       <= '0;
            exp_b       <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            iter        <= '0;
            result_r    <= '0;
            invalid_r   <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r  <= 1'b0;
                        sign_r      <= a_sign ^ b_sign;
                        exp_a       <= a_exp;
                        exp_b       <= b_exp;
                        mcand       <= {1'b1, a_frac};
                        mplier      <= {1'b1, b_frac};
                        acc         <= '0;
                        iter        <= '0;
                        overflow_r  <= 1'b0;
                        underflow_r <= 1'b0;
                        if (is_special) begin
                            result_r  <= special_result;
                            invalid_r <= special_invalid;
                            state     <= DONE;
                        end else begin
                            invalid_r <= 1'b0;
                            state     <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc    <= {step_sum, acc[M-1:1]};
                    mplier <= mplier >> 1;
                    if (iter == LAST_ITER) begin
                        state <= NORM;
                    end else begin
                        iter <= iter + CW'(1);
                    end
                end
                NORM: begin
                    result_r    <= norm_result;
                    overflow_r  <= norm_ovf;
                    underflow_r <= norm_unf;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    // Special cases arrive with out_valid low and raise it here.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
